// File: rtl/parity_stream_decoder.sv
// Streaming parity checker with a 2-entry result FIFO and saturating word/error counters.
// Accepts one codeword per handshake and passes the message through with a parity-error flag.
module parity_stream_decoder #(
    parameter int DATA_W = 4,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:0]   codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] message,
    output logic              status,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam logic ODD_B = (ODD != 0);

    logic [DATA_W:0]  ent_q [2];
    logic [DATA_W:0]  ent_d [2];
    logic             rd_q, rd_d, wr_q, wr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] word_q, word_d, err_q, err_d;
    logic             acc, pop, perr;

    // Flow control comes from registered occupancy only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign {status, message} = ent_q[rd_q];
    assign word_cnt  = word_q;
    assign err_cnt   = err_q;

    assign acc  = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    assign perr = (^codeword) ^ ODD_B;

    always_comb begin
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        rd_d     = rd_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        err_d    = err_q;

        if (acc) begin
            ent_d[wr_q] = {perr, codeword[DATA_W-1:0]};
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({acc, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Clear wins over a same-cycle accept: that word goes uncounted.
        if (clr_cnt) begin
            word_d = '0;
            err_d  = '0;
        end else if (acc) begin
            if (word_q != '1) word_d = word_q + 1'b1;
            if (perr && (err_q != '1)) err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
            word_q   <= '0;
            err_q    <= '0;
        end else begin
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_parity_stream_decoder.sv
// Scoreboard bench: an even-mode/8-bit-counter DUT and an odd-mode/2-bit-counter DUT
// share one stimulus stream and are checked against a queue-based reference model.
module tb_parity_stream_decoder;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, clr_cnt;
    logic [4:0] codeword;

    logic       ir0, ov0, st0, ir1, ov1, st1;
    logic [3:0] msg0, msg1;
    logic [7:0] wc0, ec0;
    logic [1:0] wc1, ec1;

    always #5 clk = ~clk;

    parity_stream_decoder #(.DATA_W(4), .ODD(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .codeword(codeword),
        .out_valid(ov0), .out_ready(out_ready), .message(msg0), .status(st0),
        .clr_cnt(clr_cnt), .word_cnt(wc0), .err_cnt(ec0));

    parity_stream_decoder #(.DATA_W(4), .ODD(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .codeword(codeword),
        .out_valid(ov1), .out_ready(out_ready), .message(msg1), .status(st1),
        .clr_cnt(clr_cnt), .word_cnt(wc1), .err_cnt(ec1));

    typedef struct {
        logic [3:0] msg;
        logic       se;
        logic       so;
    } exp_t;

    exp_t q[$];
    int   occ = 0;
    int   w0 = 0, e0 = 0, w1 = 0, e1 = 0;
    bit   armed = 0;
    int   ncmp = 0, nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, acceptance order and counters straight from the rules.
    always @(posedge clk) begin
        bit acc, pp;
        if (rst) begin
            occ = 0; q.delete();
            w0 = 0; e0 = 0; w1 = 0; e1 = 0;
            armed = 1;
        end else begin
            acc = in_valid && (occ != 2);
            pp  = out_ready && (occ != 0);
            if (acc) begin
                exp_t e;
                e.msg = codeword[3:0];
                e.se  = ^codeword;
                e.so  = ~(^codeword);
                q.push_back(e);
            end
            if (clr_cnt) begin
                w0 = 0; e0 = 0; w1 = 0; e1 = 0;
            end else if (acc) begin
                w0 = (w0 == 255) ? 255 : w0 + 1;
                w1 = (w1 == 3) ? 3 : w1 + 1;
                if (^codeword)    e0 = (e0 == 255) ? 255 : e0 + 1;
                if (!(^codeword)) e1 = (e1 == 3) ? 3 : e1 + 1;
            end
            occ = occ + int'(acc) - int'(pp);
        end
    end

    // Monitor: samples mid-cycle after inputs for the next edge are settled.
    always begin
        @(negedge clk);
        #1;
        if (armed) begin
            chk("in_ready0", 32'(ir0), 32'(occ != 2));
            chk("in_ready1", 32'(ir1), 32'(occ != 2));
            chk("out_valid0", 32'(ov0), 32'(occ != 0));
            chk("out_valid1", 32'(ov1), 32'(occ != 0));
            chk("word_cnt0", 32'(wc0), 32'(w0));
            chk("err_cnt0", 32'(ec0), 32'(e0));
            chk("word_cnt1", 32'(wc1), 32'(w1));
            chk("err_cnt1", 32'(ec1), 32'(e1));
            if (ov0 === 1'b1 && out_ready && !rst) begin
                if (q.size() == 0) begin
                    chk("pop_on_empty", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("message0", 32'(msg0), 32'(e.msg));
                    chk("message1", 32'(msg1), 32'(e.msg));
                    chk("status_even", 32'(st0), 32'(e.se));
                    chk("status_odd", 32'(st1), 32'(e.so));
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [4:0] cw, input bit ordy,
                         input bit clr, input bit r);
        @(negedge clk);
        in_valid  = v;
        codeword  = cw;
        out_ready = ordy;
        clr_cnt   = clr;
        rst       = r;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; codeword = '0;
        drive(0, 5'b00000, 0, 0, 1);
        drive(0, 5'b00000, 0, 0, 1);
        // Even stream with a free-running consumer
        drive(1, 5'b00000, 1, 0, 0);
        drive(1, 5'b00011, 1, 0, 0);
        drive(1, 5'b00001, 1, 0, 0);
        drive(1, 5'b10001, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        // Odd-mode pair (checked on dut1)
        drive(1, 5'b00000, 1, 0, 0);
        drive(1, 5'b10000, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        // Backpressure: third word held until the cycle after the first pop
        drive(1, 5'b00001, 0, 1, 0);
        drive(1, 5'b00010, 0, 0, 0);
        drive(1, 5'b00100, 0, 0, 0);
        drive(1, 5'b00100, 0, 0, 0);
        drive(1, 5'b00100, 1, 0, 0);
        drive(1, 5'b00100, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        // Saturation: even-error words then odd-error words
        drive(0, 5'b00000, 1, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 5'b00001, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 5'b00000, 1, 0, 0);
        // Clear in the same cycle as an accepted error word
        drive(1, 5'b00001, 1, 1, 0);
        drive(0, 5'b00000, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        // Reset with two entries buffered and a word on the input
        drive(1, 5'b00101, 0, 0, 0);
        drive(1, 5'b01110, 0, 0, 0);
        drive(1, 5'b11111, 0, 0, 1);
        drive(1, 5'b00110, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        drive(0, 5'b00000, 1, 0, 0);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) < 7), 5'($urandom), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
        end
        for (int i = 0; i < 4; i++) drive(0, 5'b00000, 1, 0, 0);
        @(negedge clk);
        #2;
        chk("drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/parity_stream_decoder.md
# parity_stream_decoder

Streaming, parametrised successor to the single-word parity decoder. It accepts one (DATA_W+1)-bit codeword per cycle over a valid/ready handshake and checks parity in even or odd mode. It buffers results in a 2-entry output FIFO that absorbs downstream backpressure, and keeps saturating counts of words checked and parity errors seen. It sits between the channel deframer and the message consumer in the decode datapath.

## Interface
- DATA_W, 4: message width; codeword width is DATA_W+1.
- ODD, 0: parity mode; 0 = even parity, 1 = odd parity.
- CNT_W, 8: width of the word and error counters.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  codeword present.
- in_ready  out  1  block can accept a codeword this cycle.
- codeword  in  DATA_W+1  bit DATA_W is the parity bit; bits DATA_W-1:0 are the message.
- out_valid  out  1  head FIFO entry is valid.
- out_ready  in  1  consumer takes the head entry.
- message  out  DATA_W  message field of the head entry.
- status  out  1  head entry parity result; 1 = parity error.
- clr_cnt  in  1  synchronous clear of both counters.
- word_cnt  out  CNT_W  words accepted since reset/clear; saturates at all-ones.
- err_cnt  out  CNT_W  words accepted with status=1; saturates at all-ones.

## Operation
- Accept occurs when in_valid && in_ready at a rising edge. Pop occurs when out_valid && out_ready at a rising edge.
- Parity check:
  - Even mode (ODD=0): status = XOR of all DATA_W+1 codeword bits.
  - Odd mode (ODD=1): status = inverted XOR of all DATA_W+1 codeword bits.
- The message is passed through unmodified, including on error. No correction is performed.
- Output FIFO:
  - 2 entries, each holding {status, message}, with occupancy count 0..2.
  - in_ready = (count != 2). This depends on registered state only; it never depends combinationally on out_ready or in_valid.
  - When full, no accept happens, even if a pop occurs the same cycle. in_ready rises the cycle after the pop.
  - Simultaneous accept and pop with count=1: count stays 1. The new entry becomes head after the old head leaves.
  - Entries leave in acceptance order.
- out_valid = (count != 0). message and status always reflect the head entry. Their values are don't-care while out_valid=0.
- Counters:
  - On accept, word_cnt += 1, and err_cnt += 1 if the computed status = 1.
  - Each counter holds at all-ones once it reaches all-ones (2^CNT_W-1).
  - clr_cnt=1 sets both counters to 0 at the edge. It takes priority over a same-cycle accept; that word is not counted.
  - clr_cnt does not affect FIFO contents.
- Reset: rst=1 at an edge empties the FIFO and zeroes both counters. Any in-flight entries are discarded, and any word presented during the reset cycle is not accepted.

## Timing
- Reset values: out_valid=0, in_ready=1, word_cnt=0, err_cnt=0. message and status are don't-care (implement as 0).
- Latency: a word accepted at edge k into an empty FIFO is visible with out_valid=1 immediately after edge k, i.e. in the next cycle.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Counter outputs are registered and reflect an accept from edge k immediately after edge k.
- in_ready is low during reset assertion only if the FIFO was already full; after the reset edge it is 1.
- No combinational path exists from in_valid or codeword to any output.

## Test plan
- Even mode (DATA_W=4), out_ready=1, stream 00000, 00011, 00001, 10001:
  - Outputs one per cycle: (0000,0), (0011,0), (0001,1), (0001,0).
  - Final counts: word_cnt=4, err_cnt=1.
- Odd mode (ODD=1), codewords 00000 then 10000:
  - Response: status=1 then status=0.
  - Messages are 0000 both times.
- Backpressure, out_ready=0, in_valid=1 with 00001, 00010, 00100:
  - in_ready drops after 2 accepts, and the third word is held.
  - Raise out_ready: outputs 0001, 0010, 0100 in order, with the third accepted the cycle after the first pop.
  - word_cnt=3.
- Saturation, CNT_W=2:
  - Send 5 error words.
  - Response: err_cnt and word_cnt stop at 3.
- Clear priority:
  - Assert clr_cnt in the same cycle as an accepted error word.
  - Response: both counters read 0 next cycle, and the word still appears at the output with status=1.
- Reset mid-operation:
  - With 2 entries buffered, assert rst for one cycle.
  - Response: out_valid=0, in_ready=1, counters=0.
  - The next word accepted is the first output seen.
